// File: rtl/rpspmc_filter_pkg.sv
// Shared types and helpers for the RPSPMC biquad filter chain.
package rpspmc_filter_pkg;

    // Storage width of one coefficient word on the config bus.
    localparam int COEF_W   = 32;
    // Working width for saturation helpers; wide enough for any accumulator here.
    localparam int SAT_MAXW = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WB,
        ST_OUT
    } state_t;

    // Tap order within one section's MAC sequence.
    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

    typedef struct packed {
        logic signed [COEF_W-1:0] b0;
        logic signed [COEF_W-1:0] b1;
        logic signed [COEF_W-1:0] b2;
        logic signed [COEF_W-1:0] a1;
        logic signed [COEF_W-1:0] a2;
    } coef_t;

    // Symmetric clamp of v to a signed w-bit range.
    function automatic logic signed [SAT_MAXW-1:0] sat_w(
        input logic signed [SAT_MAXW-1:0] v,
        input int                         w
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = (SAT_MAXW'(1) <<< (w - 1)) - SAT_MAXW'(1);
        lo = -(SAT_MAXW'(1) <<< (w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        return v;
    endfunction

    // Drop the headroom LSBs and clamp to the output sample width.
    function automatic logic signed [SAT_MAXW-1:0] sat_out(
        input logic signed [SAT_MAXW-1:0] v,
        input int                         shift,
        input int                         w
    );
        return sat_w(v >>> shift, w);
    endfunction

    // Pass-through section: b0 = 1.0 in Q format, everything else zero.
    function automatic coef_t coef_unity(input int q);
        coef_t c;
        c    = '0;
        c.b0 = COEF_W'(1) << q;
        return c;
    endfunction

endpackage

// File: rtl/biquad_mac_unit.sv
// Shared multiply-accumulate for all biquad sections, with Q shift and saturation.
module biquad_mac_unit
    import rpspmc_filter_pkg::*;
#(
    parameter int W  = 36,
    parameter int CW = 32,
    parameter int Q  = 28
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_en,
    input  logic [2:0]           i_tap,
    input  logic signed [W-1:0]  i_sample,
    input  logic signed [CW-1:0] i_coef,
    output logic signed [W-1:0]  o_y
);

    localparam int AW = W + CW + 3;

    logic signed [W+CW-1:0] w_prod;
    logic signed [AW-1:0]   w_term;
    logic signed [AW-1:0]   r_acc;

    assign w_prod = i_sample * i_coef;
    assign w_term = AW'(w_prod);

    // Accumulate one product per enabled cycle; feedback taps are subtracted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= (i_tap >= TAP_A1) ? (r_acc - w_term) : (r_acc + w_term);
        end
    end

    assign o_y = W'(sat_w(SAT_MAXW'(r_acc) >>> Q, W));

endmodule

// File: rtl/axis_biquad_cascade.sv
// Cascade of DF-1 biquads sharing one MAC, AXI-Stream in/out, per-section config.
module axis_biquad_cascade
    import rpspmc_filter_pkg::*;
#(
    parameter int signal_width          = 32,
    parameter int coefficient_width     = 32,
    parameter int coefficient_Q         = 28,
    parameter int internal_extra        = 4,
    parameter int n_sections            = 4,
    parameter int configuration_address = 999
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [31:0]             config_addr,
    input  logic [511:0]            config_data,
    input  logic [signal_width-1:0] S_AXIS_in_tdata,
    input  logic                    S_AXIS_in_tvalid,
    output logic                    S_AXIS_in_tready,
    output logic [signal_width-1:0] M_AXIS_out_tdata,
    output logic                    M_AXIS_out_tvalid,
    input  logic                    M_AXIS_out_tready,
    output logic [signal_width-1:0] M_AXIS_pass_tdata,
    output logic                    M_AXIS_pass_tvalid
);

    localparam int W  = signal_width + internal_extra;
    localparam int SW = (n_sections > 1) ? $clog2(n_sections) : 1;
    localparam logic [SW-1:0] LAST_SEC = SW'(n_sections - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [2:0]              r_tap;
    logic [SW-1:0]           r_sec;
    logic signed [W-1:0]     r_x;
    logic signed [W-1:0]     r_x1 [n_sections];
    logic signed [W-1:0]     r_x2 [n_sections];
    logic signed [W-1:0]     r_y1 [n_sections];
    logic signed [W-1:0]     r_y2 [n_sections];
    coef_t                   r_coef [n_sections];
    logic [signal_width-1:0] r_out_data;

    logic [31:0]             w_cfg_off;
    logic                    w_cfg_hit;
    logic [SW-1:0]           w_cfg_sec;
    logic                    w_in_hs;
    logic                    w_last;
    logic                    w_mac_clear;
    logic                    w_mac_en;
    logic signed [W-1:0]     w_op;
    logic signed [COEF_W-1:0] w_coef_sel;
    logic signed [W-1:0]     w_y;
    logic                    w_unused_cfg;

    assign w_cfg_off    = config_addr - 32'(configuration_address);
    assign w_cfg_hit    = (config_addr >= 32'(configuration_address)) && (w_cfg_off < 32'(n_sections));
    assign w_cfg_sec    = w_cfg_off[SW-1:0];
    assign w_unused_cfg = ^{config_data[511:192], config_data[127:96]};

    assign M_AXIS_pass_tdata  = S_AXIS_in_tdata;
    assign M_AXIS_pass_tvalid = S_AXIS_in_tvalid;
    assign M_AXIS_out_tdata   = r_out_data;

    assign w_in_hs = S_AXIS_in_tvalid && S_AXIS_in_tready;
    assign w_last  = (r_sec == LAST_SEC);

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic; a matching config write always returns to IDLE.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_in_hs) w_next = ST_MAC;
            ST_MAC:  if (r_tap == TAP_A2) w_next = ST_WB;
            ST_WB:   w_next = w_last ? ST_OUT : ST_MAC;
            ST_OUT:  if (M_AXIS_out_tready) w_next = ST_IDLE;
        endcase
        if (w_cfg_hit) w_next = ST_IDLE;
    end

    // FSM outputs: handshakes and MAC control, all suppressed during config writes.
    always_comb begin
        S_AXIS_in_tready  = (r_state == ST_IDLE) && !w_cfg_hit;
        M_AXIS_out_tvalid = (r_state == ST_OUT) && !w_cfg_hit;
        w_mac_en          = (r_state == ST_MAC) && !w_cfg_hit;
        w_mac_clear       = w_cfg_hit || w_in_hs || (r_state == ST_WB);
    end

    // Select the operand/coefficient pair for the current tap of the current section.
    always_comb begin
        w_op       = r_x;
        w_coef_sel = r_coef[r_sec].b0;
        case (r_tap)
            TAP_B1: begin w_op = r_x1[r_sec]; w_coef_sel = r_coef[r_sec].b1; end
            TAP_B2: begin w_op = r_x2[r_sec]; w_coef_sel = r_coef[r_sec].b2; end
            TAP_A1: begin w_op = r_y1[r_sec]; w_coef_sel = r_coef[r_sec].a1; end
            TAP_A2: begin w_op = r_y2[r_sec]; w_coef_sel = r_coef[r_sec].a2; end
            default: ;
        endcase
    end

    biquad_mac_unit #(
        .W  (W),
        .CW (coefficient_width),
        .Q  (coefficient_Q)
    ) u_mac (
        .clk      (aclk),
        .rst_n    (aresetn),
        .i_clear  (w_mac_clear),
        .i_en     (w_mac_en),
        .i_tap    (r_tap),
        .i_sample (w_op),
        .i_coef   (coefficient_width'(w_coef_sel)),
        .o_y      (w_y)
    );

    // Datapath: coefficient load, sample capture, tap/section sequencing, history writeback.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tap      <= '0;
            r_sec      <= '0;
            r_x        <= '0;
            r_out_data <= '0;
            for (int unsigned i = 0; i < n_sections; i++) begin
                r_coef[i] <= coef_unity(coefficient_Q);
                r_x1[i]   <= '0;
                r_x2[i]   <= '0;
                r_y1[i]   <= '0;
                r_y2[i]   <= '0;
            end
        end else if (w_cfg_hit) begin
            r_coef[w_cfg_sec].b0 <= config_data[31:0];
            r_coef[w_cfg_sec].b1 <= config_data[63:32];
            r_coef[w_cfg_sec].b2 <= config_data[95:64];
            r_coef[w_cfg_sec].a1 <= config_data[159:128];
            r_coef[w_cfg_sec].a2 <= config_data[191:160];
            r_tap <= '0;
            r_sec <= '0;
            for (int unsigned i = 0; i < n_sections; i++) begin
                r_x1[i] <= '0;
                r_x2[i] <= '0;
                r_y1[i] <= '0;
                r_y2[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_hs) begin
                        r_x   <= W'($signed(S_AXIS_in_tdata)) <<< internal_extra;
                        r_tap <= '0;
                        r_sec <= '0;
                    end
                end
                ST_MAC: r_tap <= r_tap + 3'd1;
                ST_WB: begin
                    r_x1[r_sec] <= r_x;
                    r_x2[r_sec] <= r_x1[r_sec];
                    r_y1[r_sec] <= w_y;
                    r_y2[r_sec] <= r_y1[r_sec];
                    r_x         <= w_y;
                    r_tap       <= '0;
                    if (w_last) r_out_data <= signal_width'(sat_out(SAT_MAXW'(w_y), internal_extra, signal_width));
                    else        r_sec      <= r_sec + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_biquad_cascade.sv
// Directed scoreboard bench for axis_biquad_cascade (default parameters).
module tb_axis_biquad_cascade;

    localparam int          BASE  = 999;
    localparam logic [31:0] UNITY = 32'h1000_0000;
    localparam logic [31:0] HALF  = 32'h0800_0000;
    localparam logic [31:0] GAIN4 = 32'h4000_0000;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [31:0]  config_addr;
    logic [511:0] config_data;
    logic [31:0]  S_AXIS_in_tdata;
    logic         S_AXIS_in_tvalid;
    logic         S_AXIS_in_tready;
    logic [31:0]  M_AXIS_out_tdata;
    logic         M_AXIS_out_tvalid;
    logic         M_AXIS_out_tready;
    logic [31:0]  M_AXIS_pass_tdata;
    logic         M_AXIS_pass_tvalid;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    axis_biquad_cascade #(
        .signal_width          (32),
        .coefficient_width     (32),
        .coefficient_Q         (28),
        .internal_extra        (4),
        .n_sections            (4),
        .configuration_address (BASE)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .config_addr        (config_addr),
        .config_data        (config_data),
        .S_AXIS_in_tdata    (S_AXIS_in_tdata),
        .S_AXIS_in_tvalid   (S_AXIS_in_tvalid),
        .S_AXIS_in_tready   (S_AXIS_in_tready),
        .M_AXIS_out_tdata   (M_AXIS_out_tdata),
        .M_AXIS_out_tvalid  (M_AXIS_out_tvalid),
        .M_AXIS_out_tready  (M_AXIS_out_tready),
        .M_AXIS_pass_tdata  (M_AXIS_pass_tdata),
        .M_AXIS_pass_tvalid (M_AXIS_pass_tvalid)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] cfg_word(input logic [31:0] b0, b1, b2, a1, a2);
        logic [511:0] d;
        d          = '0;
        d[31:0]    = b0;
        d[63:32]   = b1;
        d[95:64]   = b2;
        d[127:96]  = 32'hDEAD_BEEF;
        d[159:128] = a1;
        d[191:160] = a2;
        return d;
    endfunction

    task automatic cfg(input int k, input logic [31:0] b0, b1, b2, a1, a2);
        @(negedge aclk);
        config_addr = 32'(BASE + k);
        config_data = cfg_word(b0, b1, b2, a1, a2);
        @(negedge aclk);
        config_addr = 32'd0;
    endtask

    // Waits (bounded) for tready, then performs one input handshake; returns just after that edge.
    task automatic send(input logic [31:0] d, input bit keep, input logic [31:0] exp);
        int n;
        n = 0;
        @(negedge aclk);
        while (!S_AXIS_in_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("in_ready_timeout", 64'(n < 200), 64'd1);
        S_AXIS_in_tdata  = d;
        S_AXIS_in_tvalid = 1'b1;
        @(posedge aclk);
        if (keep) exp_q.push_back(exp);
        #1 S_AXIS_in_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge aclk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    // Output side of the scoreboard: every output handshake must match the oldest expectation.
    always @(negedge aclk) begin
        if (aresetn && M_AXIS_out_tvalid && M_AXIS_out_tready) begin
            check("out_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("out_data", 64'(M_AXIS_out_tdata), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        aresetn           = 1'b0;
        config_addr       = 32'd0;
        config_data       = '0;
        S_AXIS_in_tdata   = 32'h1234_5678;
        S_AXIS_in_tvalid  = 1'b1;
        M_AXIS_out_tready = 1'b1;

        // Reset values and combinational pass-through.
        repeat (3) @(negedge aclk);
        check("rst_in_tready", 64'(S_AXIS_in_tready), 64'd1);
        check("rst_out_tvalid", 64'(M_AXIS_out_tvalid), 64'd0);
        check("rst_out_tdata", 64'(M_AXIS_out_tdata), 64'd0);
        check("pass_tdata", 64'(M_AXIS_pass_tdata), 64'h1234_5678);
        check("pass_tvalid", 64'(M_AXIS_pass_tvalid), 64'd1);
        S_AXIS_in_tvalid = 1'b0;
        #1 check("pass_tvalid_low", 64'(M_AXIS_pass_tvalid), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        // Default coefficients: unity cascade, 25-cycle latency.
        send(32'd1000, 1'b1, 32'd1000);
        lat = 0;
        do begin
            @(negedge aclk);
            lat++;
            if (lat == 1) check("busy_in_tready", 64'(S_AXIS_in_tready), 64'd0);
        end while (!M_AXIS_out_tvalid && lat < 100);
        check("latency", 64'(lat), 64'd25);
        drain();

        // Section 0 as two-tap average.
        cfg(0, HALF, HALF, 32'd0, 32'd0, 32'd0);
        send(32'd1000, 1'b1, 32'd500);
        send(32'd1000, 1'b1, 32'd1000);
        drain();

        // Saturation in both directions.
        cfg(0, GAIN4, 32'd0, 32'd0, 32'd0, 32'd0);
        send(32'h7000_0000, 1'b1, 32'h7FFF_FFFF);
        send(32'h9000_0000, 1'b1, 32'h8000_0000);
        drain();

        // Output backpressure.
        M_AXIS_out_tready = 1'b0;
        send(32'd1000, 1'b1, 32'd4000);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!M_AXIS_out_tvalid && n < 200);
        check("bp_valid_timeout", 64'(n < 200), 64'd1);
        repeat (10) begin
            check("bp_tvalid", 64'(M_AXIS_out_tvalid), 64'd1);
            check("bp_tdata", 64'(M_AXIS_out_tdata), 64'd4000);
            check("bp_in_tready", 64'(S_AXIS_in_tready), 64'd0);
            @(negedge aclk);
        end
        @(posedge aclk);
        #1 M_AXIS_out_tready = 1'b1;
        @(negedge aclk);
        check("bp_in_tready_hs", 64'(S_AXIS_in_tready), 64'd0);
        @(posedge aclk);
        @(negedge aclk);
        check("bp_in_tready_after", 64'(S_AXIS_in_tready), 64'd1);
        drain();

        // Config write mid-flight drops the sample; defaults still pass 1000.
        cfg(0, UNITY, 32'd0, 32'd0, 32'd0, 32'd0);
        send(32'd1000, 1'b0, 32'd0);
        repeat (7) @(posedge aclk);
        #1 config_addr = 32'(BASE + 2);
        config_data = cfg_word(UNITY, 32'd0, 32'd0, 32'd0, 32'd0);
        #2 check("cfg_in_tready", 64'(S_AXIS_in_tready), 64'd0);
        @(posedge aclk);
        #1 config_addr = 32'd0;
        repeat (40) @(negedge aclk);
        check("drop_tvalid", 64'(M_AXIS_out_tvalid), 64'd0);
        check("drop_in_tready", 64'(S_AXIS_in_tready), 64'd1);
        send(32'd1000, 1'b1, 32'd1000);
        drain();

        // History cleared by a mid-flight write: averaging section sees x1 = 0.
        cfg(0, HALF, HALF, 32'd0, 32'd0, 32'd0);
        send(32'd3000, 1'b0, 32'd0);
        repeat (7) @(posedge aclk);
        #1 config_addr = 32'(BASE + 3);
        config_data = cfg_word(UNITY, 32'd0, 32'd0, 32'd0, 32'd0);
        @(posedge aclk);
        #1 config_addr = 32'd0;
        repeat (40) @(negedge aclk);
        send(32'd1000, 1'b1, 32'd500);
        drain();

        // Asynchronous reset during section 0 writeback.
        cfg(0, GAIN4, 32'd0, 32'd0, 32'd0, 32'd0);
        send(32'd1000, 1'b0, 32'd0);
        repeat (5) @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check("arst_tvalid", 64'(M_AXIS_out_tvalid), 64'd0);
        check("arst_in_tready", 64'(S_AXIS_in_tready), 64'd1);
        check("arst_tdata", 64'(M_AXIS_out_tdata), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        send(32'd1000, 1'b1, 32'd1000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_biquad_cascade.md
# axis_biquad_cascade

Parametrised cascade of `n_sections` Direct-Form-1 biquad IIR sections. All sections share one time-multiplexed multiply-accumulate unit. The block has a full AXI-Stream valid/ready handshake on input and output, per-section coefficient banks loaded over the common `config_addr`/`config_data` bus, and saturating arithmetic. It sits in the RPSPMC signal chain wherever a higher-order low-pass or notch filter is needed on a decimated signal stream.

## Interface
Parameters:
- `signal_width`, 32: stream sample width, signed.
- `coefficient_width`, 32: coefficient width, signed. Must be ≥ `coefficient_Q`+2.
- `coefficient_Q`, 28: coefficient fractional bits.
- `internal_extra`, 4: extra LSB headroom bits on internal state.
- `n_sections`, 4: number of cascaded biquads, 1..8.
- `configuration_address`, 999: base address. Section k is written at base+k.

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `config_addr` in 32: configuration address.
- `config_data` in 512: 32-bit words 0..5 = b0, b1, b2, a0 (ignored), a1, a2.
- `S_AXIS_in_tdata` in `signal_width`: input sample.
- `S_AXIS_in_tvalid` in 1: input valid.
- `S_AXIS_in_tready` out 1: block can accept a sample.
- `M_AXIS_out_tdata` out `signal_width`: filtered sample.
- `M_AXIS_out_tvalid` out 1: output valid.
- `M_AXIS_out_tready` in 1: downstream accepts the output.
- `M_AXIS_pass_tdata` out `signal_width`: combinational copy of `S_AXIS_in_tdata`.
- `M_AXIS_pass_tvalid` out 1: combinational copy of `S_AXIS_in_tvalid`.

## Operation
- Width rule: W = `signal_width`+`internal_extra`. Internal state is W bits. The input is sign-extended and shifted left by `internal_extra`.
- Accumulator width: W+`coefficient_width`+3.
- Per section k: y = sat_W((b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2) >>> Q). The shift is arithmetic and the saturation is symmetric clamp to [−2^(W−1), 2^(W−1)−1].
- Section k's y is section k+1's x.
- Final output: sat_signal_width(y_last >>> `internal_extra`).
- Each section keeps its own history registers x1, x2, y1, y2. They are updated only at that section's writeback.
- FSM states:
  - IDLE: tready=1. On handshake, latch x and go to MAC with section 0, tap 0.
  - MAC: one product per cycle, taps 0..4, accumulated. After tap 4, go to WB.
  - WB: shift and saturate, update history, section++. Go to MAC if more sections remain, else OUT.
  - OUT: tvalid=1 and tdata held stable. On tready, go to IDLE.
- Config write: active on any cycle where `config_addr` ∈ [base, base+`n_sections`−1].
  - Loads that section's coefficients.
  - Clears all section histories.
  - Forces IDLE and drops any in-flight sample; no output is produced for it.
  - Holds tready=0 for as long as the address matches.
  - Output tvalid is cleared; any pending output is discarded.
- Addresses outside the range are ignored.

## Timing
- Reset values:
  - `S_AXIS_in_tready`=1 (IDLE state), `M_AXIS_out_tvalid`=0, `M_AXIS_out_tdata`=0.
  - All histories and the accumulator = 0.
  - Coefficients: b0 = 1<<Q (exact unity), all others 0.
- Reset asserts asynchronously and releases synchronously to `aclk`.
- Latency: tvalid rises 6·`n_sections`+1 cycles after the input handshake (25 cycles for 4 sections).
- Throughput: one sample per 6·`n_sections`+2 cycles when there is no backpressure.
- tready is low from the cycle after the handshake until the cycle after the output handshake.
- A new sample can be accepted in the cycle immediately after the output handshake.
- Reset asserted mid-operation: immediate return to reset values and no output.
- If a config write and an input handshake occur in the same cycle, the config write wins. This cannot actually happen, because tready is 0 during a matching config cycle.

## Structure
- Shared package `rpspmc_filter_pkg` holds:
  - FSM state enum,
  - the tap index constants,
  - saturate functions `sat_w` and `sat_out`,
  - the coefficient record type: five signed `coefficient_width` fields.
- Natural sub-module: `biquad_mac_unit`. It contains the shared multiplier, accumulator, shift and saturate, with tap-select and clear inputs.
- The top level holds the FSM, coefficient and history arrays, and the handshakes.

## Test plan
- Reset, defaults, `n_sections`=4: input 1000 -> output 1000 with tvalid exactly 25 cycles after the handshake; reset values checked before the first sample.
- Section 0 configured as b0=b1=1<<27, all other sections default: inputs 1000, 1000 -> outputs 500, 1000.
- Saturation: section 0 b0=4<<28, input 0x7000_0000 -> output 0x7FFF_FFFF; negative input 0x9000_0000 -> output 0x8000_0000.
- Backpressure: hold `M_AXIS_out_tready`=0 for 10 cycles -> tvalid and tdata stay stable and in_tready stays 0; after release, in_tready=1 on the next cycle.
- Config write to base+2 at MAC cycle 8 -> no output for that sample and all histories zero; the next input of 1000 with defaults gives 1000.
- `aresetn` pulsed low mid-WB (asynchronously, between clock edges) -> tvalid=0, tready=1, and coefficients back to defaults immediately.
